block_mem_responder: RTL
========================

// Module: block_mem_responder
// PURPOSE
//  Memory-side responder for the data cache's block fill/writeback interface.
//  Accepts one block-granular read (fill) or write (dirty-line writeback) at a time and completes it after a fixed latency.
//  Also services a flush drain.
//  Sits between the data cache miss path and the block storage array; models main memory timing.
// PARAMETERS
//  ADDR_W      32    byte address width
//  BLOCK_W     256   block width in bits (32-byte line, offset = addr[4:0])
//  DEPTH       1024  blocks stored; index = addr[14:5]
//  READ_LAT    4     cycles from accept to resp_valid for reads (>=1)
//  WRITE_LAT   2     cycles from accept to resp_valid for writes (>=1)
// PORTS
//  clk         in   1        clock; all logic on rising edge
//  rst_n       in   1        synchronous active-low reset
//  req_valid   in   1        request present
//  req_ready   out  1        responder can accept (IDLE only)
//  req_we      in   1        1 = writeback, 0 = fill
//  req_addr    in   ADDR_W   byte address; offset bits ignored
//  req_wdata   in   BLOCK_W  writeback block, MSB = byte 0
//  resp_valid  out  1        one-cycle completion pulse
//  resp_rdata  out  BLOCK_W  fill data, valid with resp_valid on reads
//  resp_err    out  1        address >= DEPTH*32, valid with resp_valid
//  flush       in   1        level: drain and stop accepting
//  flush_done  out  1        high while flush && nothing pending
// BEHAVIOUR
//  Reset (rst_n=0 at edge): req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, flush_done=0.
//  State goes to IDLE; first cycle after reset req_ready=1. Array contents are NOT reset.
//  FSM: IDLE -> BUSY on accept (req_valid&&req_ready); BUSY -> RESP when counter hits 0; RESP -> IDLE next cycle.
//  Accept at edge T: address, we and wdata are captured; counter loads LAT-1.
//  resp_valid is high exactly in cycle T+LAT (READ_LAT or WRITE_LAT), for one cycle only.
//  Back-to-back: req_ready returns in cycle T+LAT+1.
//  req_ready = IDLE && !flush. Inputs are ignored when not ready; no buffering of refused requests.
//  Write commits to the array on the edge that raises resp_valid. Reset before that edge drops the write.
//  Reads sample the array at that same edge; data written earlier is always visible.
//  Out of range: resp_err=1, resp_rdata=0, write dropped; latency unchanged.
//  Reset mid-BUSY: operation aborted, no resp_valid issued.
//  flush rising while BUSY: the current op completes normally. flush_done=1 from the first IDLE cycle with flush high.
//  flush_done drops the cycle after flush falls.
//  flush and req_valid in the same IDLE cycle: flush wins, request not accepted.
// CONFIGURATION
//  BLOCK_MEM_WRBUF_EN defined: writes are posted.
//   - Accept is followed by resp_valid at T+1. The block sits in a 1-entry buffer, committing WRITE_LAT cycles after accept.
//   - A read hitting the buffered index returns the buffered data.
//   - A second write while the buffer is full holds req_ready=0 until commit.
//   - flush_done additionally requires the buffer empty.
//  Not defined: all writes are non-posted as above; no buffer logic.
// STRUCTURE
//  Shared package mem_pkg holds:
//   - BLOCK_W, OFFSET_LEN=5, INDEX_LEN
//   - responder state enum {IDLE,BUSY,RESP}
//   - mem_req_t struct (we, addr, wdata)
//  Cache and responder both import mem_pkg.
//  One sub-module: block_mem_array (single-port DEPTH x BLOCK_W synchronous RAM, write enable, registered read).
//  Responder keeps only the FSM, latency counter and optional write buffer.
// TESTING
//  1 Reset then read 0x0000_0040 -> resp_valid exactly 4 cycles after accept, rdata = preloaded block 2, err=0.
//  2 Write 0x80 with data D, then read 0x9F -> write resp at T+2, read returns D. req_ready low between the two requests.
//  3 Read 0x0010_0000 (beyond DEPTH) -> resp_err=1, rdata=0. A following write there is dropped and leaves the array unchanged.
//  4 rst_n low 2 cycles after accepting a write to 0x20 -> no resp_valid. Later read of 0x20 returns the old data.
//  5 flush raised mid-read -> read completes; flush_done=1 next IDLE cycle. req_valid during flush is never accepted.
//  6 (WRBUF_EN) write 0x40 then immediate read 0x40 -> write resp at T+1, read returns the new data before commit.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared block-memory types for the data cache miss path and the responder.
// Geometry: 32-byte lines, 1024-entry backing store.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int BLOCK_W = 256;
  localparam int DEPTH = 1024;
  localparam int OFFSET_LEN = 5;
  localparam int INDEX_LEN = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } rsp_state_e;

  typedef struct packed {
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/block_mem_array.sv
// Single-port DEPTH x WIDTH synchronous block RAM with registered read.
// Contents are never reset.
module block_mem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/block_mem_responder.sv
// Fixed-latency block fill/writeback responder with flush drain.
// Define BLOCK_MEM_WRBUF_EN for posted writes through a 1-entry buffer.
module block_mem_responder #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int BLOCK_W = mem_pkg::BLOCK_W,
  parameter int DEPTH = mem_pkg::DEPTH,
  parameter int READ_LAT = 4,
  parameter int WRITE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [BLOCK_W-1:0] req_wdata,
  output logic               resp_valid,
  output logic [BLOCK_W-1:0] resp_rdata,
  output logic               resp_err,
  input  logic               flush,
  output logic               flush_done
);

  import mem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - OFFSET_LEN;
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W = $clog2(MAX_LAT + 1);
  localparam logic [TAG_W-1:0] LIMIT = TAG_W'(DEPTH);

  rsp_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wlat_load;
  mem_req_t         cur;
  logic             cur_oor;
  logic             in_oor;
  logic             accept;
  logic             fire;
  logic             nxt_idle;
  logic             drain;
  logic [IDX_W-1:0] cur_idx;

  logic               mem_en;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_q;
  logic [BLOCK_W-1:0] rd_data;
  logic               unused_bits;

  assign in_oor = req_addr[ADDR_W-1:OFFSET_LEN] >= LIMIT;
  assign cur_idx = cur.addr[OFFSET_LEN +: IDX_W];
  assign fire = (state == BUSY) && (cnt == '0);
  assign accept = req_valid && req_ready;
  assign nxt_idle = (state == RESP) || ((state == IDLE) && !accept);

`ifdef BLOCK_MEM_WRBUF_EN
  logic               wb_valid;
  logic [IDX_W-1:0]   wb_idx;
  logic [BLOCK_W-1:0] wb_data;
  logic [CNT_W-1:0]   wb_cnt;
  logic               rd_fire;
  logic               wb_commit;
  logic               fwd_hit;
  logic [BLOCK_W-1:0] fwd_data;

  assign rd_fire = rst_n && fire && !cur.we && !cur_oor;
  // A read owns the single port; a due commit slips a cycle, forwarding covers it.
  assign wb_commit = rst_n && wb_valid && (wb_cnt == '0) && !rd_fire;
  assign req_ready = rst_n && (state == IDLE) && !flush
                     && !(req_we && wb_valid);
  assign mem_en = rd_fire || wb_commit;
  assign mem_we = !rd_fire;
  assign mem_idx = rd_fire ? cur_idx : wb_idx;
  assign mem_wdata = wb_data;
  assign rd_data = fwd_hit ? fwd_data : mem_q;
  assign wlat_load = '0;
  assign drain = !wb_valid || wb_commit;
  assign unused_bits = ^{req_addr[OFFSET_LEN-1:0], cur.addr[OFFSET_LEN-1:0],
                         cur.addr[ADDR_W-1:OFFSET_LEN+IDX_W], cur.wdata};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_cnt <= '0;
      fwd_hit <= 1'b0;
    end else begin
      if (accept && req_we && !in_oor) begin
        wb_valid <= 1'b1;
        wb_idx <= req_addr[OFFSET_LEN +: IDX_W];
        wb_data <= req_wdata;
        wb_cnt <= CNT_W'(WRITE_LAT - 1);
      end else if (wb_commit) begin
        wb_valid <= 1'b0;
      end else if (wb_valid && (wb_cnt != '0)) begin
        wb_cnt <= wb_cnt - 1'b1;
      end
      if (rd_fire) begin
        fwd_hit <= wb_valid && (wb_idx == cur_idx);
        fwd_data <= wb_data;
      end
    end
  end
`else
  assign req_ready = rst_n && (state == IDLE) && !flush;
  // Gating with rst_n lets a reset on the commit edge drop the write.
  assign mem_en = rst_n && fire && !cur_oor;
  assign mem_we = cur.we;
  assign mem_idx = cur_idx;
  assign mem_wdata = cur.wdata;
  assign rd_data = mem_q;
  assign wlat_load = CNT_W'(WRITE_LAT - 1);
  assign drain = 1'b1;
  assign unused_bits = ^{req_addr[OFFSET_LEN-1:0], cur.addr[OFFSET_LEN-1:0],
                         cur.addr[ADDR_W-1:OFFSET_LEN+IDX_W]};
`endif

  assign resp_rdata = (resp_valid && !resp_err && !cur.we) ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      cur_oor <= 1'b0;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      flush_done <= flush && nxt_idle && drain;
      unique case (state)
        IDLE: begin
          if (accept) begin
            cur <= '{we: req_we, addr: req_addr, wdata: req_wdata};
            cur_oor <= in_oor;
            cnt <= req_we ? wlat_load : CNT_W'(READ_LAT - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_err <= cur_oor;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  block_mem_array #(
    .DEPTH(DEPTH),
    .WIDTH(BLOCK_W),
    .IDX_W(IDX_W)
  ) u_array (
    .clk(clk),
    .en(mem_en),
    .we(mem_we),
    .idx(mem_idx),
    .wdata(mem_wdata),
    .rdata(mem_q)
  );

endmodule
